subtract_2stage: RTL and testbench

- Two-stage pipelined unsigned 32-bit subtractor; companion to the 2-stage pipelined adder.
- Computes out_diff = {1'b0,in_1} - {1'b0,in_2} as a 33-bit two's-complement result. Bit 32 is the borrow/sign.
- Split into a low-half stage and a high-half stage, with the borrow registered between them.
- Adds a valid/ready handshake on both sides so it can sit in backpressured datapaths.

---
 rtl/subtract_2stage.sv | 88 ++++++++
 tb/tb_subtract_2stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/subtract_2stage.sv
// Two-stage pipelined unsigned subtractor with valid/ready on both sides.
// Optional SUBTRACT_2STAGE_CLAMP_EN saturates negative results to zero.
module subtract_2stage #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned LO_WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_diff
);

  localparam int unsigned HI_WIDTH = WIDTH - LO_WIDTH;

  logic                s1_valid;
  logic [LO_WIDTH-1:0] s1_lo_diff;
  logic                s1_lo_borrow;
  logic [HI_WIDTH-1:0] s1_hi_1;
  logic [HI_WIDTH-1:0] s1_hi_2;

  logic                s2_adv_c;
  logic                s1_adv_c;
  logic [LO_WIDTH-1:0] lo_diff_c;
  logic                lo_borrow_c;
  logic [HI_WIDTH:0]   hi_full_c;
  logic [WIDTH:0]      diff_c;

  // Handshake: a stage advances when its downstream slot is free or draining
  always_comb begin
    s2_adv_c = !out_valid || out_ready;
    s1_adv_c = !s1_valid || s2_adv_c;
    in_ready = s1_adv_c;
  end

  // Low half resolved on the raw operands, borrow carried into stage 2
  always_comb begin
    lo_diff_c   = in_1[LO_WIDTH-1:0] - in_2[LO_WIDTH-1:0];
    lo_borrow_c = in_1[LO_WIDTH-1:0] < in_2[LO_WIDTH-1:0];
  end

  // High half consumes the registered borrow; top bit is the full result sign
  always_comb begin
    hi_full_c = {1'b0, s1_hi_1} - {1'b0, s1_hi_2} - {{HI_WIDTH{1'b0}}, s1_lo_borrow};
`ifdef SUBTRACT_2STAGE_CLAMP_EN
    diff_c = hi_full_c[HI_WIDTH] ? '0 : {hi_full_c, s1_lo_diff};
`else
    diff_c = {hi_full_c, s1_lo_diff};
`endif
  end

  // Stage 1 registers
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid     <= 1'b0;
      s1_lo_diff   <= '0;
      s1_lo_borrow <= 1'b0;
      s1_hi_1      <= '0;
      s1_hi_2      <= '0;
    end else if (s1_adv_c) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_lo_diff   <= lo_diff_c;
        s1_lo_borrow <= lo_borrow_c;
        s1_hi_1      <= in_1[WIDTH-1:LO_WIDTH];
        s1_hi_2      <= in_2[WIDTH-1:LO_WIDTH];
      end
    end
  end

  // Stage 2 registers drive the outputs directly
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_diff  <= '0;
    end else if (s2_adv_c) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_diff <= diff_c;
      end
    end
  end

endmodule

// File: tb/tb_subtract_2stage.sv
// Scoreboard bench for subtract_2stage: directed latency/value cases, streaming,
// backpressure and mid-stream reset. Honours SUBTRACT_2STAGE_CLAMP_EN.
module tb_subtract_2stage;
  localparam int unsigned W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_1;
  logic [W-1:0] in_2;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   out_diff;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W:0] sb[$];
  logic       stall_q = 1'b0;
  logic [W:0] held_q  = '0;

  always #5 clock = ~clock;

  subtract_2stage #(.WIDTH(32), .LO_WIDTH(16)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_1(in_1), .in_2(in_2),
    .out_valid(out_valid), .out_ready(out_ready), .out_diff(out_diff)
  );

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] d;
    d = {1'b0, a} - {1'b0, b};
`ifdef SUBTRACT_2STAGE_CLAMP_EN
    if (d[W]) d = '0;
`endif
    return d;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor on the falling edge: scoreboard push/pop and stall stability
  always @(negedge clock) begin
    logic [W:0] exp;
    if (reset) begin
      sb.delete();
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", 64'(out_diff), 64'(held_q));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_out", 64'd1, 64'd0);
        else begin
          exp = sb.pop_front();
          check("data", 64'(out_diff), 64'(exp));
        end
      end
      if (in_valid && in_ready) sb.push_back(model(in_1, in_2));
      stall_q = out_valid && !out_ready;
      held_q  = out_diff;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Hold an operand pair until it is accepted (bounded)
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    logic r;
    int   n;
    in_valid = 1'b1; in_1 = a; in_2 = b;
    n = 0;
    forever begin
      @(negedge clock);
      r = in_ready;
      tick();
      if (r) break;
      n++;
      if (n > 50) begin
        check("send_timeout", 64'd0, 64'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Single op into an empty pipe: exact latency and constant expected value
  task automatic single_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W:0] expv);
    out_ready = 1'b1;
    in_valid = 1'b1; in_1 = a; in_2 = b;
    tick();
    in_valid = 1'b0;
    @(negedge clock);
    check({tag, "_lat1"}, 64'(out_valid), 64'd0);
    @(negedge clock);
    check({tag, "_lat2"}, 64'(out_valid), 64'd1);
    check(tag, 64'(out_diff), 64'(expv));
    tick();
  endtask

  logic [W:0] underflow_exp;
  logic [W:0] cross2_exp;
  logic [W-1:0] sa[8];
  logic [W-1:0] sbv[8];

  initial begin
`ifdef SUBTRACT_2STAGE_CLAMP_EN
    underflow_exp = '0;
    cross2_exp    = '0;
`else
    underflow_exp = 33'h1_FFFF_FFFF;
    cross2_exp    = 33'h1_1000_0010;
`endif
    reset = 1'b1; in_valid = 1'b0; in_1 = '0; in_2 = '0; out_ready = 1'b1;
    tick(); tick();
    @(negedge clock);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_diff", 64'(out_diff), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    tick();
    reset = 1'b0;

    single_op("basic", 32'd9273, 32'd3827, 33'd5446);
    single_op("cross1", 32'h0001_0000, 32'h0000_0001, 33'h0_0000_FFFF);
    single_op("cross2", 32'h0FFF_FFFF, 32'hFFFF_FFEF, cross2_exp);
    single_op("underflow", 32'd0, 32'd1, underflow_exp);

    // Back-to-back stream of 8, expecting an unbroken run of 8 outputs
    sa  = '{32'd13442, 32'd200, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd12345, 32'hDEAD_BEEF};
    sbv = '{32'd10042, 32'd100, 32'd0, 32'd9253, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd54321, 32'h1234_5678};
    fork
      begin
        for (int i = 0; i < 8; i++) send(sa[i], sbv[i]);
      end
      begin
        int k = 0;
        int w = 0;
        @(negedge clock);
        while (!out_valid && w < 20) begin w++; @(negedge clock); end
        while (out_valid && k < 20) begin k++; @(negedge clock); end
        check("stream_run", 64'(k), 64'd8);
      end
    join
    repeat (3) tick();

    // Backpressure: 4 ops, out_ready low for 3 cycles once both stages fill
    fork
      begin
        send(32'd1000, 32'd1); send(32'd2000, 32'd2);
        send(32'd3000, 32'd3); send(32'd4000, 32'd4);
      end
      begin
        tick(); tick();
        out_ready = 1'b0;
        @(negedge clock);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        tick(); tick(); tick();
        out_ready = 1'b1;
      end
    join
    repeat (4) tick();
    check("bp_drained", 64'(sb.size()), 64'd0);

    // Random stream with random backpressure
    fork
      begin
        for (int i = 0; i < 40; i++) send(W'($urandom), W'($urandom));
      end
      begin
        for (int i = 0; i < 120; i++) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    repeat (6) tick();
    check("rand_drained", 64'(sb.size()), 64'd0);

    // Reset with two ops in flight
    out_ready = 1'b1;
    send(32'd500, 32'd5); send(32'd600, 32'd6);
    reset = 1'b1;
    tick();
    @(negedge clock);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_diff", 64'(out_diff), 64'd0);
    tick();
    reset = 1'b0;
    single_op("post_rst", 32'd77, 32'd7, 33'd70);
    repeat (3) begin
      @(negedge clock);
      check("post_rst_idle", 64'(out_valid), 64'd0);
    end
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
